// File: rtl/game_flow_controller.sv
// game_flow_controller: dino game sequencer.
// Runs IDLE/PLAYING/CRASH_HOLD/GAME_OVER and paces obstacles from
// the frame tick. It keeps a 4-digit BCD score and a speed level.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_tick         frame tick pulse (60 Hz)
//   i_start        start/restart request pulse
//   i_crash        collision level
//   o_state        0 idle, 1 playing, 2 crash hold, 3 game over
//   o_obs_step     obstacle advance pulse
//   o_step_px      pixels per step (BASE_PX + level)
//   o_level        speed level
//   o_score        BCD score
//   o_game_over_pulse  pulse on entry to crash hold
//   o_freeze       high when not playing
//   o_hiscore      BCD best score
// Optional feature macro: HISCORE_EN (best-score tracking).
module game_flow_controller #(
  parameter int SCORE_DIV  = 6,
  parameter int BASE_PX    = 1,
  parameter int MAX_LEVEL  = 4,
  parameter int HOLD_TICKS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic        i_crash,
  output logic [1:0]  o_state,
  output logic        o_obs_step,
  output logic [3:0]  o_step_px,
  output logic [2:0]  o_level,
  output logic [15:0] o_score,
  output logic        o_game_over_pulse,
  output logic        o_freeze,
  output logic [15:0] o_hiscore
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAYING    = 2'd1,
    CRASH_HOLD = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam logic [5:0] DIV_LAST  = 6'(SCORE_DIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
  localparam logic [2:0] LVL_MAX   = 3'(MAX_LEVEL);
  localparam logic [3:0] PX_BASE   = 4'(BASE_PX);

  state_t      state, state_d;
  logic [5:0]  div, div_d;
  logic [7:0]  hold, hold_d;
  logic [15:0] score_d;
  logic [2:0]  level_d;
  logic        step_d;
  logic        gop_d;

  // BCD +1 with per-digit carry; 9999 saturates.
  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      div               <= '0;
      hold              <= '0;
      o_score           <= '0;
      o_level           <= '0;
      o_step_px         <= PX_BASE;
      o_obs_step        <= 1'b0;
      o_game_over_pulse <= 1'b0;
      o_freeze          <= 1'b1;
    end else begin
      state             <= state_d;
      div               <= div_d;
      hold              <= hold_d;
      o_score           <= score_d;
      o_level           <= level_d;
      o_step_px         <= PX_BASE + {1'b0, level_d};
      o_obs_step        <= step_d;
      o_game_over_pulse <= gop_d;
      o_freeze          <= (state_d != PLAYING);
    end
  end

  // Next state.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, GAME_OVER: begin
        if (i_start) state_d = PLAYING;
      end
      PLAYING: begin
        if (i_crash) state_d = CRASH_HOLD;
      end
      CRASH_HOLD: begin
        if (i_tick && hold == HOLD_LAST)
          state_d = GAME_OVER;
      end
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    div_d   = div;
    hold_d  = hold;
    score_d = o_score;
    level_d = o_level;
    step_d  = 1'b0;
    gop_d   = 1'b0;
    unique case (state)
      IDLE, GAME_OVER: begin
        if (i_start) begin
          div_d   = '0;
          hold_d  = '0;
          score_d = '0;
          level_d = '0;
        end
      end
      PLAYING: begin
        // Crash beats a coincident tick.
        if (i_crash) begin
          gop_d  = 1'b1;
          hold_d = '0;
        end else if (i_tick) begin
          step_d = 1'b1;
          if (div == DIV_LAST) begin
            div_d = '0;
            if (o_score != 16'h9999) begin
              score_d = bcd_inc(o_score);
              // Crossing a multiple of 100.
              if (o_score[7:0] == 8'h99 &&
                  o_level < LVL_MAX)
                level_d = o_level + 3'd1;
            end
          end else begin
            div_d = div + 6'd1;
          end
        end
      end
      CRASH_HOLD: begin
        if (i_tick) begin
          if (hold == HOLD_LAST) hold_d = '0;
          else hold_d = hold + 8'd1;
        end
      end
    endcase
  end

  assign o_state = state;

`ifdef HISCORE_EN
  logic [15:0] hiscore;

  // Valid BCD orders the same as plain binary,
  // so a 16-bit compare is a digit-wise compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      hiscore <= '0;
    end else if (state == PLAYING && i_crash &&
                 o_score > hiscore) begin
      hiscore <= o_score;
    end
  end

  assign o_hiscore = hiscore;
`else
  assign o_hiscore = 16'h0000;
`endif

endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: directed bench for game_flow_controller.
// Main instance uses defaults; a SCORE_DIV=1 instance covers 9999.
module tb_game_flow_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic tick = 1'b0, start = 1'b0, crash = 1'b0;
  logic tick_f = 1'b0, start_f = 1'b0, crash_f = 1'b0;

  logic [1:0]  st, st_f;
  logic        step, step_f;
  logic [3:0]  px, px_f;
  logic [2:0]  lvl, lvl_f;
  logic [15:0] score, score_f;
  logic        gop, gop_f;
  logic        frz, frz_f;
  logic [15:0] hs, hs_f;

`ifdef HISCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  game_flow_controller dut (
    .clk(clk), .rst(rst),
    .i_tick(tick), .i_start(start), .i_crash(crash),
    .o_state(st), .o_obs_step(step),
    .o_step_px(px), .o_level(lvl),
    .o_score(score), .o_game_over_pulse(gop),
    .o_freeze(frz), .o_hiscore(hs)
  );

  game_flow_controller #(.SCORE_DIV(1)) dut_f (
    .clk(clk), .rst(rst),
    .i_tick(tick_f), .i_start(start_f),
    .i_crash(crash_f),
    .o_state(st_f), .o_obs_step(step_f),
    .o_step_px(px_f), .o_level(lvl_f),
    .o_score(score_f), .o_game_over_pulse(gop_f),
    .o_freeze(frz_f), .o_hiscore(hs_f)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    cyc(n);
    tick = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("rst_state", st, 0);
    chk("rst_step", step, 0);
    chk("rst_px", px, 1);
    chk("rst_lvl", lvl, 0);
    chk("rst_score", score, 0);
    chk("rst_gop", gop, 0);
    chk("rst_frz", frz, 1);
    chk("rst_hs", hs, 0);
    chk("rst_state_f", st_f, 0);
    rst = 1'b0;

    tick = 1'b1; crash = 1'b1;
    cyc();
    tick = 1'b0; crash = 1'b0;
    chk("idle_state", st, 0);
    chk("idle_step", step, 0);
    chk("idle_gop", gop, 0);

    start = 1'b1; crash = 1'b1;
    cyc();
    start = 1'b0; crash = 1'b0;
    chk("start_state", st, 1);
    chk("start_frz", frz, 0);
    chk("start_score", score, 0);
    chk("start_px", px, 1);
    chk("start_gop", gop, 0);

    for (int i = 0; i < 12; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("step_on", step, 1);
      cyc();
      chk("step_off", step, 0);
    end
    chk("score12", score, 16'h0002);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("play_start_st", st, 1);
    chk("play_start_sc", score, 16'h0002);

    ticks(240);
    chk("score42", score, 16'h0042);

    tick = 1'b1; crash = 1'b1;
    cyc();
    tick = 1'b0; crash = 1'b0;
    chk("crash_state", st, 2);
    chk("crash_step", step, 0);
    chk("crash_score", score, 16'h0042);
    chk("crash_gop", gop, 1);
    chk("crash_frz", frz, 1);
    chk("crash_hs", hs, HS ? 16'h0042 : 16'h0);
    cyc();
    chk("gop_off", gop, 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("hold_start", st, 2);
    ticks(29);
    chk("hold29", st, 2);
    ticks(1);
    chk("hold30", st, 3);
    chk("go_score", score, 16'h0042);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_st", st, 1);
    chk("restart_sc", score, 0);
    chk("restart_lvl", lvl, 0);

    ticks(102);
    chk("score17", score, 16'h0017);
    crash = 1'b1;
    cyc();
    crash = 1'b0;
    chk("crash2_state", st, 2);
    chk("crash2_gop", gop, 1);
    chk("crash2_hs", hs, HS ? 16'h0042 : 16'h0);
    ticks(30);
    chk("go2", st, 3);

    start = 1'b1;
    cyc();
    start = 1'b0;
    ticks(594);
    chk("score99", score, 16'h0099);
    chk("lvl99", lvl, 0);
    chk("px99", px, 1);
    ticks(6);
    chk("score100", score, 16'h0100);
    chk("lvl100", lvl, 1);
    chk("px100", px, 2);
    ticks(1800);
    chk("score400", score, 16'h0400);
    chk("lvl400", lvl, 4);
    ticks(600);
    chk("score500", score, 16'h0500);
    chk("lvl500", lvl, 4);
    chk("px500", px, 5);
    ticks(600);
    chk("score600", score, 16'h0600);
    chk("lvl600", lvl, 4);
    chk("px600", px, 5);

    crash = 1'b1;
    cyc();
    crash = 1'b0;
    chk("crash3_hs", hs, HS ? 16'h0600 : 16'h0);
    ticks(30);
    start = 1'b1;
    cyc();
    start = 1'b0;
    ticks(6);
    chk("g4_state", st, 1);
    chk("g4_score", score, 16'h0001);

    rst = 1'b1; tick = 1'b1; crash = 1'b1;
    cyc();
    rst = 1'b0; tick = 1'b0; crash = 1'b0;
    chk("mid_rst_st", st, 0);
    chk("mid_rst_sc", score, 0);
    chk("mid_rst_frz", frz, 1);
    chk("mid_rst_lvl", lvl, 0);
    chk("mid_rst_step", step, 0);
    chk("mid_rst_gop", gop, 0);
    chk("mid_rst_hs", hs, 0);

    start_f = 1'b1;
    cyc();
    start_f = 1'b0;
    chk("f_state", st_f, 1);
    tick_f = 1'b1;
    cyc(9999);
    chk("f_9999", score_f, 16'h9999);
    chk("f_lvl", lvl_f, 4);
    chk("f_px", px_f, 5);
    cyc(20);
    tick_f = 1'b0;
    chk("f_sat", score_f, 16'h9999);
    chk("f_sat_lvl", lvl_f, 4);
    chk("f_hs", hs_f, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
